// File: rtl/next_pc_unit_pkg.sv
// Shared encodings and default parameters for the next-PC unit.
package next_pc_unit_pkg;

    localparam int unsigned DefAddrW   = 32;
    localparam int unsigned DefJidxW   = 26;
    localparam logic [31:0] DefResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        ModeNone   = 2'b00,
        ModeBranch = 2'b01,
        ModeJump   = 2'b10,
        ModeJr     = 2'b11
    } redir_mode_e;

    typedef enum logic {
        StRun       = 1'b0,
        StHoldRedir = 1'b1
    } npc_state_e;

endpackage

// File: rtl/next_pc_unit_target_gen.sv
// Combinational redirect target formation for branch, jump and register-jump.
module pc_target_gen
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned JIDX_W = DefJidxW
) (
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_pc,
    input  logic [15:0]       imm16,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] target,
    output logic              misalign
);

    localparam int unsigned LowW = JIDX_W + 2;
    // Covers the jidx/word-offset field; all ones when no upper PC bits remain.
    localparam logic [ADDR_W-1:0] LowMask = {ADDR_W{1'b1}} >> (ADDR_W - LowW);

    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    assign branch_tgt = base_pc + ADDR_W'($signed({imm16, 2'b00}));
    assign jump_tgt   = (base_pc & ~LowMask) | ADDR_W'({jidx, 2'b00});
    assign jr_tgt     = {jr_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        target   = '0;
        misalign = 1'b0;
        case (redir_mode_e'(mode))
            ModeBranch: target = branch_tgt;
            ModeJump:   target = jump_tgt;
            ModeJr: begin
                target   = jr_tgt;
                misalign = |jr_target[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register with stall handling and a one-deep latched redirect.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DefAddrW,
    parameter int unsigned       JIDX_W   = DefJidxW,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_mode,
    input  logic [ADDR_W-1:0] base_pc,
    input  logic [15:0]       imm16,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              redirected,
    output logic              pending,
    output logic              misalign
);

    npc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              lmis_q, lmis_d;
    logic              redirected_q, redirected_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] new_tgt;
    logic              new_mis;
    logic              redir;

    pc_target_gen #(
        .ADDR_W (ADDR_W),
        .JIDX_W (JIDX_W)
    ) u_target_gen (
        .mode      (redirect_mode),
        .base_pc   (base_pc),
        .imm16     (imm16),
        .jidx      (jidx),
        .jr_target (jr_target),
        .target    (new_tgt),
        .misalign  (new_mis)
    );

    assign redir    = redirect_valid && (redirect_mode != ModeNone);
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        lmis_d       = lmis_q;
        redirected_d = 1'b0;
        misalign_d   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (redir && !stall) begin
                    pc_d         = new_tgt;
                    redirected_d = 1'b1;
                    misalign_d   = new_mis;
                end else if (redir) begin
                    tgt_d   = new_tgt;
                    lmis_d  = new_mis;
                    state_d = StHoldRedir;
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
            end
            StHoldRedir: begin
                if (stall) begin
                    if (redir) begin
                        tgt_d  = new_tgt;
                        lmis_d = new_mis;
                    end
                end else begin
                    // A redirect arriving on the release cycle is younger than the latched one.
                    pc_d         = redir ? new_tgt : tgt_q;
                    misalign_d   = redir ? new_mis : lmis_q;
                    redirected_d = 1'b1;
                    state_d      = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            lmis_q       <= 1'b0;
            redirected_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            lmis_q       <= lmis_d;
            redirected_q <= redirected_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc         = pc_q;
    assign pending    = (state_q == StHoldRedir);
    assign redirected = redirected_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit with hand-computed expectations.
module tb_next_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_mode;
    logic [31:0] base_pc;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirected;
    logic        pending;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    next_pc_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_mode  (redirect_mode),
        .base_pc        (base_pc),
        .imm16          (imm16),
        .jidx           (jidx),
        .jr_target      (jr_target),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .redirected     (redirected),
        .pending        (pending),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        redirect_valid = 1'b0;
        redirect_mode  = 2'b00;
    endtask

    task automatic drive(input logic [1:0] mode, input logic [31:0] b, input logic [15:0] imm,
                         input logic [25:0] ji, input logic [31:0] jr);
        redirect_valid = 1'b1;
        redirect_mode  = mode;
        base_pc        = b;
        imm16          = imm;
        jidx           = ji;
        jr_target      = jr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 1'b1;
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'h1234_5678);
        step();
        checks++; if (pc !== 32'h0) begin failures++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if ({pending, redirected, misalign} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got=%b exp=000", {pending, redirected, misalign}); end
        checks++; if (pc_plus4 !== 32'h4) begin failures++;
            $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'h4); end
        rst_n = 1'b1;
        stall = 1'b0;
        idle();
        step();
        checks++; if (pc !== 32'h4) begin failures++;
            $display("FAIL seq_1 got=%h exp=%h", pc, 32'h4); end
        step();
        checks++; if (pc !== 32'h8 || pending !== 1'b0) begin failures++;
            $display("FAIL seq_2 got=%h/%b exp=%h/0", pc, pending, 32'h8); end
    endtask

    task automatic test_jump();
        drive(2'b10, 32'hA000_0010, 16'h0, 26'h0ABCDEF, 32'h0);
        step();
        idle();
        checks++; if (pc !== 32'hA2AF_37BC || redirected !== 1'b1) begin failures++;
            $display("FAIL jump got=%h/%b exp=%h/1", pc, redirected, 32'hA2AF_37BC); end
        step();
        checks++; if (pc !== 32'hA2AF_37C0 || redirected !== 1'b0) begin failures++;
            $display("FAIL jump_after got=%h/%b exp=%h/0", pc, redirected, 32'hA2AF_37C0); end
    endtask

    task automatic test_mode_none();
        drive(2'b00, 32'h0000_1000, 16'h0010, 26'h1, 32'h0000_2000);
        step();
        idle();
        checks++; if (pc !== 32'hA2AF_37C4 || redirected !== 1'b0) begin failures++;
            $display("FAIL mode_none got=%h/%b exp=%h/0", pc, redirected, 32'hA2AF_37C4); end
    endtask

    task automatic test_branch_wrap();
        drive(2'b01, 32'h0000_0100, 16'hFFFC, 26'h0, 32'h0);
        step();
        checks++; if (pc !== 32'h0000_00F0 || redirected !== 1'b1) begin failures++;
            $display("FAIL branch got=%h/%b exp=%h/1", pc, redirected, 32'h0000_00F0); end
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        step();
        idle();
        checks++; if (pc !== 32'hFFFF_FFFC || misalign !== 1'b0) begin failures++;
            $display("FAIL jr_top got=%h/%b exp=%h/0", pc, misalign, 32'hFFFF_FFFC); end
        step();
        checks++; if (pc !== 32'h0) begin failures++;
            $display("FAIL wrap got=%h exp=%h", pc, 32'h0); end
    endtask

    task automatic test_stall_jr();
        stall = 1'b1;
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'h0040_0000);
        step();
        idle();
        checks++; if (pc !== 32'h0 || pending !== 1'b1 || redirected !== 1'b0) begin failures++;
            $display("FAIL stall_latch got=%h/%b/%b exp=0/1/0", pc, pending, redirected); end
        step();
        step();
        checks++; if (pc !== 32'h0 || pending !== 1'b1 || redirected !== 1'b0) begin failures++;
            $display("FAIL stall_hold got=%h/%b/%b exp=0/1/0", pc, pending, redirected); end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h0040_0000 || redirected !== 1'b1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got=%h/%b/%b exp=%h/1/0", pc, redirected, pending,
                     32'h0040_0000); end
        step();
        checks++; if (pc !== 32'h0040_0004 || redirected !== 1'b0) begin failures++;
            $display("FAIL stall_after got=%h/%b exp=%h/0", pc, redirected, 32'h0040_0004); end
    endtask

    task automatic test_misalign();
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'h0040_0002);
        step();
        idle();
        checks++; if (pc !== 32'h0040_0000 || misalign !== 1'b1 || redirected !== 1'b1) begin
            failures++;
            $display("FAIL misalign got=%h/%b/%b exp=%h/1/1", pc, misalign, redirected,
                     32'h0040_0000); end
        step();
        checks++; if (pc !== 32'h0040_0004 || misalign !== 1'b0) begin failures++;
            $display("FAIL misalign_pulse got=%h/%b exp=%h/0", pc, misalign, 32'h0040_0004); end
    endtask

    task automatic test_hold_override();
        stall = 1'b1;
        drive(2'b01, 32'h0000_0100, 16'hFFFC, 26'h0, 32'h0);
        step();
        checks++; if (pc !== 32'h0040_0004 || pending !== 1'b1) begin failures++;
            $display("FAIL ovr_latch got=%h/%b exp=%h/1", pc, pending, 32'h0040_0004); end
        stall = 1'b0;
        drive(2'b10, 32'hA000_0010, 16'h0, 26'h0ABCDEF, 32'h0);
        step();
        idle();
        checks++; if (pc !== 32'hA2AF_37BC || pending !== 1'b0 || redirected !== 1'b1) begin
            failures++;
            $display("FAIL ovr_apply got=%h/%b/%b exp=%h/0/1", pc, pending, redirected,
                     32'hA2AF_37BC); end
        step();
        checks++; if (pc !== 32'hA2AF_37C0 || redirected !== 1'b0) begin failures++;
            $display("FAIL ovr_after got=%h/%b exp=%h/0", pc, redirected, 32'hA2AF_37C0); end
    endtask

    task automatic test_newest_wins();
        stall = 1'b1;
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_1000);
        step();
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_2003);
        step();
        idle();
        checks++; if (pc !== 32'hA2AF_37C0 || pending !== 1'b1 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL newest_hold got=%h/%b/%b exp=%h/1/0", pc, pending, misalign,
                     32'hA2AF_37C0); end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'h0000_2000 || misalign !== 1'b1 || redirected !== 1'b1) begin
            failures++;
            $display("FAIL newest_apply got=%h/%b/%b exp=%h/1/1", pc, misalign, redirected,
                     32'h0000_2000); end
        step();
        checks++; if (pc !== 32'h0000_2004 || misalign !== 1'b0) begin failures++;
            $display("FAIL newest_after got=%h/%b exp=%h/0", pc, misalign, 32'h0000_2004); end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1;
        drive(2'b11, 32'h0, 16'h0, 26'h0, 32'h0000_5000);
        step();
        checks++; if (pending !== 1'b1) begin failures++;
            $display("FAIL rh_pending got=%b exp=1", pending); end
        rst_n = 1'b0;
        step();
        checks++; if (pc !== 32'h0 || pending !== 1'b0 || redirected !== 1'b0) begin failures++;
            $display("FAIL rh_reset got=%h/%b/%b exp=0/0/0", pc, pending, redirected); end
        rst_n = 1'b1;
        stall = 1'b0;
        idle();
        step();
        checks++; if (pc !== 32'h4 || redirected !== 1'b0 || pending !== 1'b0) begin failures++;
            $display("FAIL rh_discard got=%h/%b/%b exp=%h/0/0", pc, redirected, pending, 32'h4);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        base_pc = '0;
        imm16 = '0;
        jidx = '0;
        jr_target = '0;
        idle();
        #2;
        test_reset();
        test_jump();
        test_mode_none();
        test_branch_wrap();
        test_stall_jr();
        test_misalign();
        test_hold_override();
        test_newest_wins();
        test_reset_in_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
